// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back data cache.
// Holds the FSM state encodings and the address-split widths.
// Helper function derives the tag width from line count and line size.
package dcache_pkg;

    localparam int unsigned DC_NUM_LINES = 16;
    localparam int unsigned DC_WORDS     = 4;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_WRITEBACK = 3'd2;
    localparam logic [2:0] ST_ALLOCATE  = 3'd3;
    localparam logic [2:0] ST_RESPOND   = 3'd4;

    // Tag is whatever is left above byte offset, word offset and index.
    function automatic int unsigned dc_tag_w(input int unsigned lines, input int unsigned words);
        return 32 - $clog2(lines) - $clog2(words) - 2;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side and memory-side handshake bundle of the data cache.
// slave: cache view (core request in, beat request out).
// master: environment view (drives core request, answers memory beats).
interface dcache_if;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [7:0]  core_wdata [0:3];
    logic [7:0]  core_rdata [0:3];
    logic        core_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one write port.
// Ports: idx selects the line for both read and write; word write and
// line-metadata write may happen in the same cycle. Only valid/dirty reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = DC_NUM_LINES,
    parameter int unsigned WORDS     = DC_WORDS,
    parameter int unsigned IDX_W     = $clog2(NUM_LINES),
    parameter int unsigned OFF_W     = $clog2(WORDS),
    parameter int unsigned TAG_W     = dc_tag_w(NUM_LINES, WORDS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [IDX_W-1:0] idx,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_line [WORDS],
    input  logic             word_we,
    input  logic [OFF_W-1:0] word_off,
    input  logic [31:0]      word_dat,
    input  logic             meta_we,
    input  logic             meta_valid,
    input  logic             meta_dirty,
    input  logic [TAG_W-1:0] meta_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[idx] <= meta_valid;
            dirty_q[idx] <= meta_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_we) tag_q[idx] <= meta_tag;
        if (word_we) data_q[idx][word_off] <= word_dat;
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller (top).
// Ports: clk, rst_b (sync, active-high), bus (dcache_if.slave); with
// DCACHE_STATS_EN defined also hit_count/miss_count saturating counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = DC_NUM_LINES,
    parameter int unsigned WORDS_PER_LINE = DC_WORDS
) (
    input  logic        clk,
    input  logic        rst_b,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned TAG_W = dc_tag_w(NUM_LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    logic [2:0]       state_q;
    logic [31:2]      addr_q;
    logic             we_q;
    logic [7:0]       wdata_q [0:3];
    logic [7:0]       rdata_q [0:3];
    logic             done_q;
    logic [OFF_W-1:0] beat_q;
    logic             mem_req_q, mem_we_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;

    logic             rd_valid, rd_dirty;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_line [WORDS_PER_LINE];
    logic             word_we, meta_we, meta_valid, meta_dirty;
    logic [OFF_W-1:0] word_off;
    logic [31:0]      word_dat;
    logic [TAG_W-1:0] meta_tag;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] beat_nxt;
    logic [31:0]      rd_word;
    logic             hit, ack, unused_addr;

    assign req_off     = addr_q[OFF_W+1:2];
    assign req_idx     = addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag     = addr_q[31:OFF_W+IDX_W+2];
    assign beat_nxt    = beat_q + 1'b1;
    assign rd_word     = rd_line[req_off];
    assign hit         = rd_valid && (rd_tag == req_tag);
    assign ack         = mem_req_q && bus.mem_ack;
    assign unused_addr = ^bus.core_addr[1:0];

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .WORDS     (WORDS_PER_LINE)
    ) u_array (
        .clk        (clk),
        .rst_b      (rst_b),
        .idx        (req_idx),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .word_we    (word_we),
        .word_off   (word_off),
        .word_dat   (word_dat),
        .meta_we    (meta_we),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty),
        .meta_tag   (meta_tag)
    );

    // Array write port. A line is invalidated as soon as its refill starts,
    // so an abandoned refill can never leave a half-written line looking valid.
    always_comb begin
        word_we    = 1'b0;
        word_off   = req_off;
        word_dat   = {wdata_q[0], wdata_q[1], wdata_q[2], wdata_q[3]};
        meta_we    = 1'b0;
        meta_valid = 1'b1;
        meta_dirty = 1'b0;
        meta_tag   = req_tag;
        if (!rst_b) begin
            case (state_q)
                ST_LOOKUP: begin
                    if (hit && we_q) begin
                        word_we    = 1'b1;
                        meta_we    = 1'b1;
                        meta_dirty = 1'b1;
                    end else if (!hit && !(rd_valid && rd_dirty)) begin
                        meta_we    = 1'b1;
                        meta_valid = 1'b0;
                    end
                end
                ST_WRITEBACK: begin
                    if (ack && beat_q == LAST_BEAT) begin
                        meta_we    = 1'b1;
                        meta_valid = 1'b0;
                    end
                end
                ST_ALLOCATE: begin
                    if (ack) begin
                        word_we  = 1'b1;
                        word_off = beat_q;
                        word_dat = bus.mem_rdata;
                        meta_we  = (beat_q == LAST_BEAT);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            rdata_q     <= '{default: 8'h00};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            beat_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.core_req) begin
                        addr_q  <= bus.core_addr[31:2];
                        we_q    <= bus.core_we;
                        wdata_q <= bus.core_wdata;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (!we_q) begin
                            for (int b = 0; b < 4; b++) rdata_q[b] <= rd_word[31-8*b -: 8];
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_RESPOND;
                    end else begin
                        beat_q    <= '0;
                        mem_req_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {rd_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                            mem_wdata_q <= rd_line[0];
                            state_q     <= ST_WRITEBACK;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                            state_q    <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (ack) begin
                        if (beat_q == LAST_BEAT) begin
                            // Refill starts on the very next cycle.
                            beat_q     <= '0;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                            state_q    <= ST_ALLOCATE;
                        end else begin
                            beat_q      <= beat_nxt;
                            mem_addr_q  <= {rd_tag, req_idx, beat_nxt, 2'b00};
                            mem_wdata_q <= rd_line[beat_nxt];
                        end
                    end
                end
                ST_ALLOCATE: begin
                    if (ack) begin
                        if (beat_q == LAST_BEAT) begin
                            mem_req_q <= 1'b0;
                            state_q   <= ST_LOOKUP;
                        end else begin
                            beat_q     <= beat_nxt;
                            mem_addr_q <= {req_tag, req_idx, beat_nxt, 2'b00};
                        end
                    end
                end
                ST_RESPOND: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Only the first LOOKUP of a request counts; the post-refill LOOKUP does not.
    logic first_q;
    always_ff @(posedge clk) begin
        if (rst_b) begin
            first_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.core_req) first_q <= 1'b1;
            if (state_q == ST_LOOKUP) begin
                first_q <= 1'b0;
                if (first_q && hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
                if (first_q && !hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

    assign bus.core_rdata = rdata_q;
    assign bus.core_done  = done_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a word-wide memory responder.
// Latency is counted in cycles from the accepting edge to the done cycle.
// Responder acks after ack_dly extra cycles and logs every beat.
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_ctrl #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory and beat log
    logic [31:0] mem_m [logic [31:0]];
    int          ack_dly    = 0;
    int          wait_cnt   = 0;
    int          stab_err   = 0;
    int          req_cycles = 0;
    logic [31:0] held_addr, held_wdata;
    logic        held_we;
    logic [31:0] beat_addr [$];
    logic        beat_we   [$];
    logic [31:0] beat_wd   [$];

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                req_cycles++;
                if (wait_cnt == 0) begin
                    held_addr  = bus.mem_addr;
                    held_we    = bus.mem_we;
                    held_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== held_addr || bus.mem_we !== held_we ||
                             bus.mem_wdata !== held_wdata) begin
                    stab_err++;
                end
                if (wait_cnt == ack_dly) begin
                    bus.mem_ack = 1'b1;
                    beat_addr.push_back(bus.mem_addr);
                    beat_we.push_back(bus.mem_we);
                    beat_wd.push_back(bus.mem_wdata);
                    if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_m.exists(bus.mem_addr) ? mem_m[bus.mem_addr] : 32'h0;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    function automatic logic [31:0] rdata_word();
        return {bus.core_rdata[0], bus.core_rdata[1], bus.core_rdata[2], bus.core_rdata[3]};
    endfunction

    task automatic clear_log();
        beat_addr.delete();
        beat_we.delete();
        beat_wd.delete();
        stab_err   = 0;
        req_cycles = 0;
    endtask

    // One core access; returns cycles from acceptance edge to the done cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat);
        @(negedge clk);
        clear_log();
        bus.core_we   = we;
        bus.core_addr = addr;
        for (int b = 0; b < 4; b++) bus.core_wdata[b] = wd[31-8*b -: 8];
        bus.core_req  = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.core_done && lat < 200);
        check_val("done_seen", {31'b0, bus.core_done}, 32'h1);
        bus.core_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat;
    int n;

    initial begin
        rst_b         = 1'b1;
        bus.core_req  = 1'b0;
        bus.core_we   = 1'b0;
        bus.core_addr = '0;
        for (int b = 0; b < 4; b++) bus.core_wdata[b] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mem_m[32'h040 + 4*i] = 32'h1111_1111 * (i + 1);
            mem_m[32'h140 + 4*i] = 32'h5555_5555 + 32'h1111_1111 * i;
            mem_m[32'h240 + 4*i] = 32'hA000_0000 + i;
            mem_m[32'h340 + 4*i] = 32'hB000_0000 + i;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_done", {31'b0, bus.core_done}, 32'h0);
        check_val("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_val("rst_rdata", rdata_word(), 32'h0);
        check_val("rst_mem_addr", bus.mem_addr, 32'h0);
        rst_b = 1'b0;

        // Cold read: clean miss, 4 refill beats
        access(1'b0, 32'h40, 32'h0, lat);
        check_val("miss_lat", lat, 7);
        check_val("miss_beats", beat_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val("miss_beat_addr", beat_addr[i], 32'h40 + 4*i);
            check_val("miss_beat_we", {31'b0, beat_we[i]}, 32'h0);
        end
        check_val("miss_rdata", rdata_word(), 32'h1111_1111);

        // Read hit
        access(1'b0, 32'h48, 32'h0, lat);
        check_val("hit_lat", lat, 2);
        check_val("hit_rdata", rdata_word(), 32'h3333_3333);
        check_val("hit_no_mem", req_cycles, 0);

        // Write hit; rdata untouched
        access(1'b1, 32'h44, 32'hDEAD_BEEF, lat);
        check_val("whit_lat", lat, 2);
        check_val("whit_no_mem", req_cycles, 0);
        check_val("whit_rdata_hold", rdata_word(), 32'h3333_3333);

        access(1'b0, 32'h44, 32'h0, lat);
        check_val("rd_after_wr", rdata_word(), 32'hDEAD_BEEF);

        // Conflict read: dirty victim written back, then refill
        access(1'b0, 32'h140, 32'h0, lat);
        check_val("dirty_lat", lat, 11);
        check_val("dirty_beats", beat_addr.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check_val("wb_addr", beat_addr[i], 32'h40 + 4*i);
            check_val("wb_we", {31'b0, beat_we[i]}, 32'h1);
            check_val("fill_addr", beat_addr[4+i], 32'h140 + 4*i);
            check_val("fill_we", {31'b0, beat_we[4+i]}, 32'h0);
        end
        check_val("wb_word0", beat_wd[0], 32'h1111_1111);
        check_val("wb_word1", beat_wd[1], 32'hDEAD_BEEF);
        check_val("dirty_rdata", rdata_word(), 32'h5555_5555);
`ifdef DCACHE_STATS_EN
        check_val("stat_hits", hit_count, 3);
        check_val("stat_misses", miss_count, 2);
`endif

        // Slow memory, clean miss
        ack_dly = 3;
        access(1'b0, 32'h248, 32'h0, lat);
        check_val("slow_lat", lat, 19);
        check_val("slow_beats", beat_addr.size(), 4);
        check_val("slow_req_cycles", req_cycles, 16);
        check_val("slow_stable", stab_err, 0);
        check_val("slow_rdata", rdata_word(), 32'hA000_0002);

        // Slow memory, dirty miss
        ack_dly = 0;
        access(1'b1, 32'h24C, 32'hCAFE_F00D, lat);
        check_val("whit2_lat", lat, 2);
        ack_dly = 3;
        access(1'b0, 32'h344, 32'h0, lat);
        check_val("slowd_lat", lat, 35);
        check_val("slowd_beats", beat_addr.size(), 8);
        check_val("slowd_stable", stab_err, 0);
        check_val("slowd_wb3_addr", beat_addr[3], 32'h24C);
        check_val("slowd_wb3_data", beat_wd[3], 32'hCAFE_F00D);
        check_val("slowd_wb2_data", beat_wd[2], 32'hA000_0002);
        check_val("slowd_rdata", rdata_word(), 32'hB000_0001);
        ack_dly = 0;

        // Bring 0x40 line back in, then reset in the middle of another refill
        access(1'b0, 32'h40, 32'h0, lat);
        check_val("pre_rst_lat", lat, 7);
        @(negedge clk);
        clear_log();
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h80;
        bus.core_req  = 1'b1;
        @(posedge clk);
        n = 0;
        while (beat_addr.size() < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("mid_beats", beat_addr.size(), 2);
        @(posedge clk);
        #1;
        rst_b        = 1'b1;
        bus.core_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_val("mid_rst_done", {31'b0, bus.core_done}, 32'h0);
        rst_b = 1'b0;

        access(1'b0, 32'h40, 32'h0, lat);
        check_val("post_rst_lat", lat, 7);
        check_val("post_rst_beats", beat_addr.size(), 4);
        check_val("post_rst_addr0", beat_addr[0], 32'h40);
        check_val("post_rst_we0", {31'b0, beat_we[0]}, 32'h0);
        check_val("post_rst_rdata", rdata_word(), 32'h1111_1111);
`ifdef DCACHE_STATS_EN
        check_val("post_rst_hits", hit_count, 0);
        check_val("post_rst_misses", miss_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
